// File: rtl/dmem_arb.sv
// dmem_arb: two-port arbiter/sequencer in front of the single-port synchronous dmem.
//
// Port 0 is the core LSU, port 1 the debug/DMA port. At most one access is granted per
// cycle (round-robin on ties), the registered dmem read data is routed back to the
// winner one cycle later, and a bounded lock keeps the bus for read-modify-write.
//
// Ports:
//   clk, reset_x                     clock (rising edge), synchronous active-low reset
//   pN_req/we/addr/wdata/lock        request from port N (N = 0, 1)
//   pN_gnt                           combinational grant, access taken this cycle
//   pN_rvalid/rdata/err              response one cycle after grant
//   dmem_addr/wdata/we, dmem_rdata   memory side
module dmem_arb #(
    parameter int unsigned MEM_DEPTH_LOG = 5,
    parameter int unsigned LOCK_MAX      = 15,
    parameter int unsigned ADDR_LEN      = 8,
    parameter int unsigned DATA_LEN      = 32
) (
    input  logic                clk,
    input  logic                reset_x,
    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [ADDR_LEN-1:0] p0_addr,
    input  logic [DATA_LEN-1:0] p0_wdata,
    input  logic                p0_lock,
    output logic                p0_gnt,
    output logic                p0_rvalid,
    output logic [DATA_LEN-1:0] p0_rdata,
    output logic                p0_err,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [ADDR_LEN-1:0] p1_addr,
    input  logic [DATA_LEN-1:0] p1_wdata,
    input  logic                p1_lock,
    output logic                p1_gnt,
    output logic                p1_rvalid,
    output logic [DATA_LEN-1:0] p1_rdata,
    output logic                p1_err,
    output logic [ADDR_LEN-1:0] dmem_addr,
    output logic [DATA_LEN-1:0] dmem_wdata,
    output logic                dmem_we,
    input  logic [DATA_LEN-1:0] dmem_rdata
);

    typedef enum logic [1:0] {StUnlocked, StLock0, StLock1} state_e;

    localparam logic [7:0] LockMax = 8'(LOCK_MAX);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] lcnt_q, lcnt_d;
    logic [1:0] perr_q, perr_d;     // forced-release error owed to each port
    logic       trk_valid_q, trk_port_q, trk_read_q, trk_err_q;
    logic       trk_valid_d, trk_port_d, trk_read_d, trk_err_d;

    logic any_gnt, grant_port, sel_we, in_range, force_rel;
    logic lock_port, own_req, own_lock;

    // Grant decode; nothing is granted while reset is held.
    always_comb begin : grant
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (reset_x) begin
            unique case (state_q)
                StUnlocked: begin
                    if (p0_req && p1_req) begin
                        p0_gnt = last_q;
                        p1_gnt = ~last_q;
                    end else begin
                        p0_gnt = p0_req;
                        p1_gnt = p1_req;
                    end
                end
                StLock0: p0_gnt = p0_req;
                StLock1: p1_gnt = p1_req;
                default: ;
            endcase
        end
    end

    assign any_gnt    = p0_gnt | p1_gnt;
    assign grant_port = p1_gnt;

    // Port 0 drives the memory bus whenever port 1 is not granted.
    assign dmem_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign dmem_wdata = p1_gnt ? p1_wdata : p0_wdata;
    assign sel_we     = p1_gnt ? p1_we    : p0_we;
    assign in_range   = (dmem_addr >> MEM_DEPTH_LOG) == '0;
    assign dmem_we    = any_gnt & sel_we & in_range;

    assign lock_port = (state_q == StLock1);
    assign own_req   = lock_port ? p1_req  : p0_req;
    assign own_lock  = lock_port ? p1_lock : p0_lock;

    always_comb begin : next_state
        state_d   = state_q;
        last_d    = last_q;
        lcnt_d    = lcnt_q;
        perr_d    = perr_q;
        force_rel = 1'b0;
        if (any_gnt) begin
            last_d = grant_port;
        end
        unique case (state_q)
            StUnlocked: begin
                if (p0_gnt && p0_lock) begin
                    state_d = StLock0;
                    lcnt_d  = '0;
                end else if (p1_gnt && p1_lock) begin
                    state_d = StLock1;
                    lcnt_d  = '0;
                end
            end
            StLock0, StLock1: begin
                lcnt_d = lcnt_q + 8'd1;
                // A voluntary release wins over a timeout in the same cycle.
                if (!own_lock && (any_gnt || !own_req)) begin
                    state_d = StUnlocked;
                end else if (lcnt_d == LockMax) begin
                    state_d   = StUnlocked;
                    last_d    = lock_port;
                    force_rel = 1'b1;
                end
            end
            default: state_d = StUnlocked;
        endcase
        if (any_gnt) begin
            perr_d[grant_port] = 1'b0;
        end
        // If the owner is granted in the timeout cycle, the error goes straight into tracking.
        if (force_rel && !any_gnt) begin
            perr_d[lock_port] = 1'b1;
        end
    end

    assign trk_valid_d = any_gnt;
    assign trk_port_d  = grant_port;
    assign trk_read_d  = ~sel_we;
    assign trk_err_d   = any_gnt & (~in_range | perr_q[grant_port] | force_rel);

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            state_q     <= StUnlocked;
            last_q      <= 1'b1;
            lcnt_q      <= '0;
            perr_q      <= '0;
            trk_valid_q <= 1'b0;
            trk_port_q  <= 1'b0;
            trk_read_q  <= 1'b0;
            trk_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lcnt_q      <= lcnt_d;
            perr_q      <= perr_d;
            trk_valid_q <= trk_valid_d;
            trk_port_q  <= trk_port_d;
            trk_read_q  <= trk_read_d;
            trk_err_q   <= trk_err_d;
        end
    end

    // Responses are suppressed while reset is held so a pending one is discarded.
    assign p0_rvalid = reset_x & trk_valid_q & ~trk_port_q;
    assign p1_rvalid = reset_x & trk_valid_q & trk_port_q;
    assign p0_err    = p0_rvalid & trk_err_q;
    assign p1_err    = p1_rvalid & trk_err_q;
    assign p0_rdata  = (p0_rvalid & trk_read_q & ~trk_err_q) ? dmem_rdata : '0;
    assign p1_rdata  = (p1_rvalid & trk_read_q & ~trk_err_q) ? dmem_rdata : '0;

endmodule

// File: doc/dmem_arb.md
# dmem_arb

Two-port arbiter and sequencer for the single-port synchronous data memory (`dmem`). It shares the memory between the core load/store unit (port 0) and the debug/DMA port (port 1), grants at most one access per cycle, and routes the 1-cycle-late read data back to the winning port. It also provides a bounded bus lock for read-modify-write sequences and flags out-of-range accesses. It sits between the LSU/debug logic and `dmem`; `dmem` is unchanged.

## Interface
Parameters:
- `MEM_DEPTH_LOG`, 5: log2 of memory words. Accesses with `addr >= 2**MEM_DEPTH_LOG` are out of range.
- `LOCK_MAX`, 15: maximum consecutive cycles a lock may be held before forced release. Range 1..255.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset_x`  in  1  synchronous, active-low reset.
- `pN_req`  in  1  access request, port N (N = 0, 1).
- `pN_we`  in  1  1 = write, 0 = read.
- `pN_addr`  in  `ADDR_LEN`  word address.
- `pN_wdata`  in  `DATA_LEN`  write data.
- `pN_lock`  in  1  request or keep bus lock with this access.
- `pN_gnt`  out  1  combinational grant; the access is taken in this cycle.
- `pN_rvalid`  out  1  response strobe, one cycle after grant, for reads and writes.
- `pN_rdata`  out  `DATA_LEN`  read data, valid with `pN_rvalid`.
- `pN_err`  out  1  out-of-range or lock-timeout flag, valid with `pN_rvalid`.
- `dmem_addr`  out  `ADDR_LEN`  to `dmem.addr`.
- `dmem_wdata`  out  `DATA_LEN`  to `dmem.wdata`.
- `dmem_we`  out  1  to `dmem.we`.
- `dmem_rdata`  in  `DATA_LEN`  from `dmem.rdata`.

## Operation
- **State machine** `{UNLOCKED, LOCK0, LOCK1}`, plus round-robin pointer `last` (the port most recently granted) and a lock counter `lcnt` (8 bits).
- **UNLOCKED:**
  - If only one port requests, that port is granted.
  - If both request, the port that is not `last` wins.
  - `last` updates on every grant.
- **Entering a lock:** granting port N with `pN_lock=1` moves the FSM to LOCKN and sets `lcnt=0`.
- **LOCKN:**
  - Only port N can be granted. The other port's `gnt` is held 0 even if it requests.
  - `lcnt` increments every cycle while in LOCKN.
  - Return to UNLOCKED when any of the following holds:
    - port N is granted with `pN_lock=0`; that access completes normally;
    - port N has `pN_req=0` and `pN_lock=0`;
    - `lcnt` reaches `LOCK_MAX`. This is a forced release: the next response to port N carries `err=1`, and `last` is set to N so the other port wins the next tie.
- **Memory drive:**
  - `dmem_addr` and `dmem_wdata` are muxed from the granted port; with no grant they come from port 0.
  - `dmem_we = gnt & pN_we & in_range`. Out-of-range writes never reach memory.
- **Response:**
  - A 1-stage tracking register holds `{valid, port, was_read, err}` for the granted access.
  - Next cycle, `pN_rvalid` pulses for exactly that port.
  - `pN_rdata = dmem_rdata` for an in-range read, and 0 for writes, errors, or when `rvalid` is low.
  - `pN_err = 1` for an out-of-range access, and for the first response after a forced lock release.
- **Throughput:** one access per cycle, back-to-back, with no bubbles.

## Timing
- **Reset** (`reset_x=0` at a clock edge):
  - FSM = UNLOCKED, `last = 1` (port 0 wins the first tie), `lcnt = 0`, tracking register cleared.
  - Next cycle: `pN_rvalid=0`, `pN_err=0`, `pN_rdata=0`.
  - While `reset_x=0`: `pN_gnt=0` and `dmem_we=0`.
- **Latency:**
  - Grant is in cycle T, combinational from `req`, `lock`, and state.
  - Response is in T+1 and matches `dmem`'s registered read.
- **Reset mid-lock or with a response pending:** the lock is dropped and the pending response is discarded (`rvalid` stays 0).
- **Requester rules:**
  - Hold `req` and all request fields stable until `gnt`.
  - A request withdrawn before `gnt` is legal and has no effect.
- **Simultaneous events:**
  - A port may request again in T+1 while its T response is being returned.
  - Both ports requesting with lock bits set in UNLOCKED: the round-robin winner takes the lock.

## Test plan
- **Reset, then back-to-back round-robin:** after `reset_x` deasserts, both ports read addr 3 continuously. Required: grants alternate p0, p1, p0, …, and each `rvalid` arrives exactly one cycle after its own grant.
- **Write then read:** p1 writes 0xDEADBEEF to addr 7 in cycle T, then reads addr 7 in T+1. Required: p1 `rvalid` pulses in T+1 with `rdata=0` and `err=0`, and again in T+2 with `rdata=0xDEADBEEF`.
- **Out-of-range write:** p0 writes addr 40 (depth 32). Required: `dmem_we=0`, p0 `err=1` next cycle, and memory is unchanged (a later read of addr 8 returns its prior value).
- **Lock:**
  - p0 performs read with `lock=1` on addr 5, then write with `lock=0` on addr 5, while p1 requests continuously. Required: p1 `gnt=0` for both p0 accesses, and p1 is granted in the following cycle.
- **Forced lock release:** `LOCK_MAX=4`; p0 holds `lock=1` and `req=0`. Required: UNLOCKED after 4 cycles, p1 granted in the next cycle, and p0's next response has `err=1`.
- **Reset mid-lock with a read pending:** assert `reset_x=0` in the cycle after p1's granted read. Required: no `rvalid` on either port, and the FSM is UNLOCKED with `last=1` after reset.
